// File: rtl/caption_draw_pkg.sv
// Shared VGA definitions for the caption overlay stage.
// Holds the coordinate/colour widths, the raster totals, the caption FSM
// state type and the packed timing+rgb bus that travels down the pipeline.
package caption_draw_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;
  localparam int ADDR_W  = 15;

  // 1024x768 @ 60 Hz raster totals
  localparam logic [COORD_W-1:0] H_TOTAL = 11'd1344;
  localparam logic [COORD_W-1:0] V_TOTAL = 11'd806;

  typedef enum logic {
    HIDDEN = 1'b0,
    SHOW   = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

endpackage

// File: rtl/caption_draw_delay.sv
// Generic shift-register delay line with synchronous reset.
//   clk, rst : clock, synchronous active-high reset (flushes to zero)
//   din      : WIDTH-bit input
//   dout     : din delayed by CLK_DEL cycles (CLK_DEL >= 1)
module caption_draw_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/caption_draw.sv
// Caption overlay stage of the VGA pixel pipeline.
// Addresses the two-plane caption ROM (bit0 = lose, bit1 = win, 1-cycle
// registered read), latches the race result, optionally blinks the caption
// and composites it over the incoming rgb stream. Every output is delayed
// exactly 3 cycles from the inputs.
//   clk, rst            : pixel clock, synchronous active-high reset
//   hcount/hsync/hblnk/vcount/vsync/vblnk/rgb _in : upstream timing + pixel
//   result_valid/win    : race-finished pulse and outcome
//   clear               : hide caption (new race)
//   rom_address         : to caption ROM
//   pixel_bit           : from caption ROM, aligned with stage 2
//   *_out               : timing delayed 3 cycles, composited rgb
module caption_draw
  import caption_draw_pkg::*;
#(
  parameter logic [COORD_W-1:0] XPOS         = 11'd340,
  parameter logic [COORD_W-1:0] YPOS         = 11'd200,
  parameter int                 CAP_W        = 344,
  parameter int                 CAP_H        = 64,
  parameter logic [RGB_W-1:0]   WIN_COLOR    = 12'h0F0,
  parameter logic [RGB_W-1:0]   LOSE_COLOR   = 12'hF00,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic               result_valid,
  input  logic               result_win,
  input  logic               clear,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [1:0]         pixel_bit,
  output logic [COORD_W-1:0] hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [COORD_W-1:0] vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam logic [COORD_W-1:0] CAP_W_C = COORD_W'(CAP_W);
  localparam logic [COORD_W-1:0] CAP_H_C = COORD_W'(CAP_H);
  localparam logic [ADDR_W-1:0]  CAP_W_A = ADDR_W'(CAP_W);
  localparam int                 CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  // ---------------- S1: geometry / address ----------------
  logic [COORD_W-1:0] dx, dy;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_nxt;

  // Unsigned wrap makes coordinates left of / above the box fail the test.
  assign dx       = hcount_in - XPOS;
  assign dy       = vcount_in - YPOS;
  assign in_box   = (dx < CAP_W_C) && (dy < CAP_H_C);
  assign addr_nxt = in_box ? (ADDR_W'(dy) * CAP_W_A + ADDR_W'(dx)) : '0;

  always_ff @(posedge clk) begin
    if (rst) rom_address <= '0;
    else     rom_address <= addr_nxt;
  end

  // ---------------- S1+S2: timing / rgb / in_box delay ----------------
  vga_bus_t bus_in, bus_d2;
  logic     in_box_d2;

  assign bus_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                    rgb: rgb_in};

  caption_draw_delay #(.WIDTH(VGA_BUS_W), .CLK_DEL(2)) u_bus_dly (
    .clk (clk),
    .rst (rst),
    .din (bus_in),
    .dout(bus_d2)
  );

  caption_draw_delay #(.WIDTH(1), .CLK_DEL(2)) u_box_dly (
    .clk (clk),
    .rst (rst),
    .din (in_box),
    .dout(in_box_d2)
  );

  // ---------------- result FSM + blink ----------------
  cap_state_t       state;
  logic             win_q;
  logic             visible;
  logic [CNT_W-1:0] frame_cnt;
  logic             vsync_q;
  logic             frame_tick;

  assign frame_tick = vsync_in & ~vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HIDDEN;
      win_q     <= 1'b0;
      visible   <= 1'b1;
      frame_cnt <= '0;
      vsync_q   <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      case (state)
        HIDDEN: begin
          // clear has priority over a simultaneous result
          if (result_valid && !clear) begin
            state     <= SHOW;
            win_q     <= result_win;
            visible   <= 1'b1;
            frame_cnt <= '0;
          end
        end
        SHOW: begin
          if (clear) begin
            state <= HIDDEN;
          end else if (BLINK_FRAMES != 0 && frame_tick) begin
            if (frame_cnt == CNT_MAX) begin
              frame_cnt <= '0;
              visible   <= ~visible;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= HIDDEN;
      endcase
    end
  end

  // ---------------- S3: composite ----------------
  logic show_px;

  // pixel_bit is the ROM response to the S1 address, so it lines up with d2.
  assign show_px = (state == SHOW) && visible && in_box_d2 && pixel_bit[win_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_d2.hcount;
      hsync_out  <= bus_d2.hsync;
      hblnk_out  <= bus_d2.hblnk;
      vcount_out <= bus_d2.vcount;
      vsync_out  <= bus_d2.vsync;
      vblnk_out  <= bus_d2.vblnk;
      if (bus_d2.hblnk || bus_d2.vblnk) rgb_out <= '0;
      else if (show_px)                 rgb_out <= win_q ? WIN_COLOR : LOSE_COLOR;
      else                              rgb_out <= bus_d2.rgb;
    end
  end

endmodule
